// File: rtl/load_pkg.sv
// Shared encodings for the RV32I load unit: funct3 codes and FSM states.
// Consumers: mem_load_unit, load_extract.
package load_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic f3_legal(input logic [2:0] f3);
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
               (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational lane select and sign/zero extension of a little-endian memory word.
module load_extract
    import load_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] data32,
    output logic [7:0]  byte8
);

    logic signed [7:0]  lane_b;
    logic signed [15:0] lane_h;

    assign lane_b = word[8*off +: 8];
    // Halfword lane uses off[1] only; off[0] is dropped when misaligned loads are not trapped.
    assign lane_h = word[16*off[1] +: 16];
    assign byte8  = lane_b;

    always_comb begin
        data32 = word;
        case (funct3)
            F3_LB:   data32 = {{24{lane_b[7]}}, lane_b};
            F3_LBU:  data32 = {24'd0, lane_b};
            F3_LH:   data32 = {{16{lane_h[15]}}, lane_h};
            F3_LHU:  data32 = {16'd0, lane_h};
            default: data32 = word;
        endcase
    end

endmodule

// File: rtl/mem_load_unit.sv
// Multi-cycle RV32I load unit: one request at a time, word read, lane extract, timeout error.
// Optional macro MISALIGN_TRAP_EN turns misaligned LH/LHU/LW into error responses.
module mem_load_unit
    import load_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TMO_W          = 8
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [4:0]  req_rd,
    output logic        mem_rd_en,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [7:0]  rsp_byte,
    output logic [4:0]  rsp_rd,
    output logic        rsp_err
);

    state_t           state, state_nx;
    logic [TMO_W-1:0] tmo_cnt;
    logic [1:0]       off_q;
    logic [2:0]       f3_q;
    logic [31:0]      ext_data;
    logic [7:0]       ext_byte;
    logic             accept;
    logic             misalign;
    logic             bad_req;
    logic             tmo_hit;

    assign req_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_RESP);
    assign accept    = req_valid && req_ready;

`ifdef MISALIGN_TRAP_EN
    assign misalign = (((req_funct3 == F3_LH) || (req_funct3 == F3_LHU)) && req_addr[0]) ||
                      ((req_funct3 == F3_LW) && (req_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign bad_req = !f3_legal(req_funct3) || misalign;
    // Fires on the last of TIMEOUT_CYCLES strobe cycles; zero disables the timeout entirely.
    assign tmo_hit = (TIMEOUT_CYCLES != 0) && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    load_extract u_extract (
        .word   (mem_rdata),
        .off    (off_q),
        .funct3 (f3_q),
        .data32 (ext_data),
        .byte8  (ext_byte)
    );

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (accept) state_nx = bad_req ? ST_RESP : ST_REQ;
            ST_REQ:  if (mem_ack || tmo_hit) state_nx = ST_RESP;
            ST_RESP: if (rsp_ready) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            tmo_cnt   <= '0;
            off_q     <= 2'd0;
            f3_q      <= 3'd0;
            mem_rd_en <= 1'b0;
            mem_addr  <= 32'd0;
            rsp_data  <= 32'd0;
            rsp_byte  <= 8'd0;
            rsp_rd    <= 5'd0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        off_q   <= req_addr[1:0];
                        f3_q    <= req_funct3;
                        rsp_rd  <= req_rd;
                        tmo_cnt <= '0;
                        if (bad_req) begin
                            rsp_err  <= 1'b1;
                            rsp_data <= 32'd0;
                            rsp_byte <= 8'd0;
                        end else begin
                            mem_rd_en <= 1'b1;
                            mem_addr  <= {req_addr[31:2], 2'b00};
                        end
                    end
                end
                ST_REQ: begin
                    // An ack in the same cycle as the timeout still wins.
                    if (mem_ack) begin
                        mem_rd_en <= 1'b0;
                        rsp_data  <= ext_data;
                        rsp_byte  <= ext_byte;
                        rsp_err   <= 1'b0;
                    end else if (tmo_hit) begin
                        mem_rd_en <= 1'b0;
                        rsp_data  <= 32'd0;
                        rsp_byte  <= 8'd0;
                        rsp_err   <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_load_unit.sv
// Scoreboard bench for mem_load_unit with TIMEOUT_CYCLES=4; honours MISALIGN_TRAP_EN.
module tb_mem_load_unit;
    import load_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [2:0]  req_funct3;
    logic [4:0]  req_rd;
    logic        mem_rd_en;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [7:0]  rsp_byte;
    logic [4:0]  rsp_rd;
    logic        rsp_err;

    typedef struct {
        logic [31:0] d;
        logic [7:0]  b;
        logic [4:0]  rd;
        logic        e;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mem_load_unit #(.TIMEOUT_CYCLES(4), .TMO_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_funct3 (req_funct3),
        .req_rd     (req_rd),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_byte   (rsp_byte),
        .rsp_rd     (rsp_rd),
        .rsp_err    (rsp_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // delay >= 0: ack after delay cycles; -1: ack never comes; -2: no memory access expected.
    task automatic do_load(input logic [31:0] addr, input logic [2:0] f3, input logic [4:0] rd,
                           input logic [31:0] rdata, input int delay,
                           input logic [31:0] ed, input logic [7:0] eb, input logic ee,
                           input int hold);
        exp_t e;
        int   n;
        sb.push_back('{d: ed, b: eb, rd: rd, e: ee});
        n = 0;
        while (!req_ready && n < 20) begin tick(); n++; end
        chk("req_ready_idle", req_ready, 1);
        req_valid  = 1'b1;
        req_addr   = addr;
        req_funct3 = f3;
        req_rd     = rd;
        tick();
        req_valid  = 1'b0;
        req_addr   = $urandom;
        req_funct3 = 3'($urandom);
        if (delay == -2) begin
            chk("no_access", mem_rd_en, 0);
        end else begin
            chk("rd_en_rise", mem_rd_en, 1);
            chk("mem_addr", mem_addr, {addr[31:2], 2'b00});
            if (delay == -1) begin
                n = 0;
                while (mem_rd_en && n < 50) begin tick(); n++; end
                chk("tmo_len", n, 4);
            end else begin
                repeat (delay) tick();
                chk("no_early_vld", rsp_valid, 0);
                mem_ack   = 1'b1;
                mem_rdata = rdata;
                tick();
                mem_ack   = 1'b0;
                mem_rdata = $urandom;
                chk("latency", rsp_valid, 1);
                chk("rd_en_drop", mem_rd_en, 0);
            end
        end
        n = 0;
        while (!rsp_valid && n < 20) begin tick(); n++; end
        e = sb.pop_front();
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_data", rsp_data, e.d);
        chk("rsp_byte", 32'(rsp_byte), 32'(e.b));
        chk("rsp_rd", 32'(rsp_rd), 32'(e.rd));
        chk("rsp_err", rsp_err, e.e);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("bp_valid", rsp_valid, 1);
            chk("bp_ready", req_ready, 0);
            chk("bp_data", rsp_data, e.d);
            chk("bp_byte", 32'(rsp_byte), 32'(e.b));
            chk("bp_err", rsp_err, e.e);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("rsp_done", rsp_valid, 0);
        chk("ready_again", req_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_addr   = 32'd0;
        req_funct3 = 3'd0;
        req_rd     = 5'd0;
        mem_ack    = 1'b0;
        mem_rdata  = 32'd0;
        rsp_ready  = 1'b0;
        repeat (3) tick();
        chk("rst_rd_en", mem_rd_en, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_data", rsp_data, 0);
        chk("rst_err", rsp_err, 0);
        chk("rst_ready", req_ready, 1);
        rst_n = 1'b1;
        tick();

        do_load(32'h103, F3_LBU, 5'd1, 32'h80AA_5512, 2, 32'h0000_0080, 8'h80, 1'b0, 0);
        do_load(32'h103, F3_LB,  5'd2, 32'h80AA_5512, 2, 32'hFFFF_FF80, 8'h80, 1'b0, 0);
        do_load(32'h102, F3_LH,  5'd3, 32'h9234_0000, 1, 32'hFFFF_9234, 8'h34, 1'b0, 0);
        do_load(32'h102, F3_LHU, 5'd4, 32'h9234_0000, 0, 32'h0000_9234, 8'h34, 1'b0, 0);
        do_load(32'h201, F3_LB,  5'd5, 32'h0000_7F00, 0, 32'h0000_007F, 8'h7F, 1'b0, 0);
        do_load(32'h200, F3_LW,  5'd6, 32'h0,        -1, 32'h0,         8'h00, 1'b1, 0);
        do_load(32'h300, F3_LW,  5'd7, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 8'hEF, 1'b0, 5);
        do_load(32'h104, 3'b011, 5'd8, 32'h0,        -2, 32'h0,         8'h00, 1'b1, 0);
        do_load(32'h104, 3'b111, 5'd9, 32'h0,        -2, 32'h0,         8'h00, 1'b1, 0);
`ifdef MISALIGN_TRAP_EN
        do_load(32'h102, F3_LW,  5'd10, 32'h1122_3344, -2, 32'h0, 8'h00, 1'b1, 0);
        do_load(32'h101, F3_LH,  5'd11, 32'h1122_3344, -2, 32'h0, 8'h00, 1'b1, 0);
`else
        do_load(32'h102, F3_LW,  5'd10, 32'h1122_3344, 1, 32'h1122_3344, 8'h22, 1'b0, 0);
        do_load(32'h101, F3_LH,  5'd11, 32'h1122_3344, 1, 32'h0000_3344, 8'h33, 1'b0, 0);
`endif

        // Reset in the middle of an outstanding read; the late ack must be ignored.
        req_valid  = 1'b1;
        req_addr   = 32'h400;
        req_funct3 = F3_LW;
        req_rd     = 5'd12;
        tick();
        req_valid  = 1'b0;
        chk("mid_rd_en", mem_rd_en, 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rd_en", mem_rd_en, 0);
        chk("async_addr", mem_addr, 0);
        chk("async_valid", rsp_valid, 0);
        tick();
        rst_n     = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        tick();
        tick();
        mem_ack   = 1'b0;
        chk("late_valid", rsp_valid, 0);
        chk("late_rd_en", mem_rd_en, 0);
        chk("late_data", rsp_data, 0);
        chk("late_rd", 32'(rsp_rd), 0);
        chk("late_err", rsp_err, 0);
        chk("late_ready", req_ready, 1);

        do_load(32'h500, F3_LW, 5'd13, 32'h0123_4567, 0, 32'h0123_4567, 8'h67, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
